// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM block: FSM encoding and default sizing.
package motor_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DEAD = 1'b1
  } state_t;

  localparam int PWM_BITS_DEF   = 8;
  localparam int DEAD_TICKS_DEF = 4;

endpackage

// File: rtl/motor_pwm_rise_detect.sv
// Turns the slow divider clock into a one-cycle tick on each rising edge,
// sampled entirely in the fast clock domain.
module rise_detect (
  input  logic clk100MHz,
  input  logic rst_n,
  input  logic clk_div,
  output logic tick
);

  logic clk_div_q;

  always_ff @(posedge clk100MHz) begin
    if (!rst_n) clk_div_q <= 1'b0;
    else        clk_div_q <= clk_div;
  end

  assign tick = clk_div & ~clk_div_q;

endmodule

// File: rtl/motor_pwm.sv
// Motor PWM generator with a one-entry command buffer and a braked dead
// interval whenever the commanded direction reverses.
module motor_pwm
  import motor_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DEAD_TICKS = DEAD_TICKS_DEF
) (
  input  logic                clk100MHz,
  input  logic                rst_n,
  input  logic                clk_div,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PWM_BITS-1:0] cmd_duty,
  input  logic                cmd_dir,
  output logic                pwm,
  output logic                dir,
  output logic                brake,
  output logic                period_start
);

  localparam logic [PWM_BITS-1:0] CNT_LAST  = PWM_BITS'((2 ** PWM_BITS) - 2);
  localparam logic [7:0]          DEAD_LAST = 8'(DEAD_TICKS - 1);

  function automatic logic pwm_level(input logic [PWM_BITS-1:0] c,
                                     input logic [PWM_BITS-1:0] d);
    return c < d;
  endfunction

  state_t              state;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty_act;
  logic [7:0]          dead_cnt;
  logic                pend_vld;
  logic [PWM_BITS-1:0] pend_duty;
  logic                pend_dir;
  logic [PWM_BITS-1:0] tgt_duty;
  logic                tgt_dir;
  logic                tick;
  logic                accept;
  logic                boundary;
  logic                enter_dead;

  rise_detect u_rise (
    .clk100MHz (clk100MHz),
    .rst_n     (rst_n),
    .clk_div   (clk_div),
    .tick      (tick)
  );

  assign cmd_ready  = ~pend_vld;
  assign accept     = cmd_valid & ~pend_vld;
  assign boundary   = tick & (state == ST_RUN) & (cnt == CNT_LAST);
  assign enter_dead = boundary & pend_vld & (pend_dir != dir);

  // Command payload and reversal target carry no reset; their valid flag
  // and the FSM decide when they are meaningful.
  always_ff @(posedge clk100MHz) begin
    if (accept) begin
      pend_duty <= cmd_duty;
      pend_dir  <= cmd_dir;
    end
    if (enter_dead) begin
      tgt_duty <= pend_duty;
      tgt_dir  <= pend_dir;
    end
  end

  always_ff @(posedge clk100MHz) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      cnt          <= '0;
      duty_act     <= '0;
      dead_cnt     <= '0;
      dir          <= 1'b0;
      pwm          <= 1'b0;
      brake        <= 1'b0;
      period_start <= 1'b0;
      pend_vld     <= 1'b0;
    end else begin
      period_start <= 1'b0;
      if (accept) pend_vld <= 1'b1;
      if (tick) begin
        if (state == ST_RUN) begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (enter_dead) begin
              state    <= ST_DEAD;
              dead_cnt <= '0;
              pend_vld <= 1'b0;
              pwm      <= 1'b0;
              brake    <= 1'b1;
            end else if (pend_vld) begin
              duty_act     <= pend_duty;
              pend_vld     <= 1'b0;
              pwm          <= pwm_level('0, pend_duty);
              period_start <= 1'b1;
            end else begin
              pwm          <= pwm_level('0, duty_act);
              period_start <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            pwm <= pwm_level(cnt + 1'b1, duty_act);
          end
        end else begin
          // Final dead tick restarts the period in the new direction.
          if (dead_cnt == DEAD_LAST) begin
            state        <= ST_RUN;
            cnt          <= '0;
            dir          <= tgt_dir;
            duty_act     <= tgt_duty;
            brake        <= 1'b0;
            pwm          <= pwm_level('0, tgt_duty);
            period_start <= 1'b1;
          end else begin
            dead_cnt <= dead_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_motor_pwm.sv
// Directed bench for motor_pwm with PWM_BITS=4 (15-tick period) and DEAD_TICKS=4.
module tb_motor_pwm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clk_div;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_duty;
  logic       cmd_dir;
  logic       pwm;
  logic       dir;
  logic       brake;
  logic       period_start;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] pp, ps, bk, dr;

  motor_pwm #(.PWM_BITS(4), .DEAD_TICKS(4)) dut (
    .clk100MHz    (clk),
    .rst_n        (rst_n),
    .clk_div      (clk_div),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_duty     (cmd_duty),
    .cmd_dir      (cmd_dir),
    .pwm          (pwm),
    .dir          (dir),
    .brake        (brake),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1);
  end

  // One clk_div pulse per iteration; outputs captured in the cycle after the tick.
  task automatic collect(input int n, output logic [31:0] p_pwm, output logic [31:0] p_ps,
                         output logic [31:0] p_bk, output logic [31:0] p_dr);
    p_pwm = '0; p_ps = '0; p_bk = '0; p_dr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); clk_div = 1'b1;
      @(negedge clk); clk_div = 1'b0;
      p_pwm[i] = pwm; p_ps[i] = period_start; p_bk[i] = brake; p_dr[i] = dir;
    end
  endtask

  task automatic send_cmd(input logic [3:0] d, input logic r);
    int waited = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_duty = d; cmd_dir = r;
    while (!cmd_ready && waited < 100) begin
      @(negedge clk); waited++;
    end
    @(negedge clk); cmd_valid = 1'b0;
    if (waited >= 100) begin
      n_vec++; n_bad++;
      $display("FAIL send_cmd_timeout ready=%b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_div = 1'b0; cmd_valid = 1'b0; cmd_duty = '0; cmd_dir = 1'b0;
    repeat (2) @(negedge clk);
    clk_div = 1'b1;
    repeat (2) @(negedge clk);
    clk_div = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (pwm !== 1'b0) begin n_bad++; $display("FAIL reset_pwm got %b want 0", pwm); end
    n_vec++; if (dir !== 1'b0) begin n_bad++; $display("FAIL reset_dir got %b want 0", dir); end
    n_vec++; if (brake !== 1'b0) begin n_bad++; $display("FAIL reset_brake got %b want 0", brake); end
    n_vec++; if (period_start !== 1'b0) begin n_bad++; $display("FAIL reset_ps got %b want 0", period_start); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_duty5();
    send_cmd(4'd5, 1'b0);
    n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL d5_pending_ready got %b want 0", cmd_ready); end
    collect(14, pp, ps, bk, dr);
    n_vec++; if (pp[13:0] !== 14'h0) begin n_bad++; $display("FAIL d5_pre_pwm got %h want 0", pp[13:0]); end
    n_vec++; if (ps[13:0] !== 14'h0) begin n_bad++; $display("FAIL d5_pre_ps got %h want 0", ps[13:0]); end
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h001F) begin n_bad++; $display("FAIL d5_pwm got %h want 001f", pp[14:0]); end
    n_vec++; if (ps[14:0] !== 15'h0001) begin n_bad++; $display("FAIL d5_ps got %h want 0001", ps[14:0]); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL d5_ready got %b want 1", cmd_ready); end
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h001F) begin n_bad++; $display("FAIL d5_pwm2 got %h want 001f", pp[14:0]); end
    n_vec++; if (ps[14:0] !== 15'h0001) begin n_bad++; $display("FAIL d5_ps2 got %h want 0001", ps[14:0]); end
  endtask

  task automatic test_duty_0_15();
    send_cmd(4'd0, 1'b0);
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h0000) begin n_bad++; $display("FAIL d0_pwm got %h want 0000", pp[14:0]); end
    n_vec++; if (ps[14:0] !== 15'h0001) begin n_bad++; $display("FAIL d0_ps got %h want 0001", ps[14:0]); end
    send_cmd(4'd15, 1'b0);
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h7FFF) begin n_bad++; $display("FAIL d15_pwm got %h want 7fff", pp[14:0]); end
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h7FFF) begin n_bad++; $display("FAIL d15_wrap_pwm got %h want 7fff", pp[14:0]); end
    n_vec++; if (ps[14:0] !== 15'h0001) begin n_bad++; $display("FAIL d15_ps got %h want 0001", ps[14:0]); end
  endtask

  task automatic test_reverse();
    send_cmd(4'd8, 1'b0);
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h00FF) begin n_bad++; $display("FAIL d8_pwm got %h want 00ff", pp[14:0]); end
    send_cmd(4'd3, 1'b1);
    collect(1, pp, ps, bk, dr);
    n_vec++; if ({bk[0], pp[0], ps[0], dr[0]} !== 4'b1000) begin
      n_bad++; $display("FAIL rev_entry brake/pwm/ps/dir got %b%b%b%b want 1000", bk[0], pp[0], ps[0], dr[0]);
    end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rev_entry_ready got %b want 1", cmd_ready); end
    send_cmd(4'd9, 1'b1);
    n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL dead_cmd_ready got %b want 0", cmd_ready); end
    collect(18, pp, ps, bk, dr);
    n_vec++; if (bk[17:0] !== 18'h00007) begin n_bad++; $display("FAIL rev_brake got %h want 00007", bk[17:0]); end
    n_vec++; if (pp[17:0] !== 18'h00038) begin n_bad++; $display("FAIL rev_pwm got %h want 00038", pp[17:0]); end
    n_vec++; if (ps[17:0] !== 18'h00008) begin n_bad++; $display("FAIL rev_ps got %h want 00008", ps[17:0]); end
    n_vec++; if (dr[17:0] !== 18'h3FFF8) begin n_bad++; $display("FAIL rev_dir got %h want 3fff8", dr[17:0]); end
    n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL dead_cmd_held got %b want 0", cmd_ready); end
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h01FF) begin n_bad++; $display("FAIL post_dead_pwm got %h want 01ff", pp[14:0]); end
    n_vec++; if (dr[14:0] !== 15'h7FFF) begin n_bad++; $display("FAIL post_dead_dir got %h want 7fff", dr[14:0]); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL post_dead_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); cmd_valid = 1'b1; cmd_duty = 4'd6; cmd_dir = 1'b1;
    @(negedge clk); cmd_duty = 4'd10;
    n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first got %b want 0", cmd_ready); end
    repeat (2) @(negedge clk);
    n_vec++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold got %b want 0", cmd_ready); end
    clk_div = 1'b1;
    @(negedge clk); clk_div = 1'b0;
    n_vec++; if ({cmd_ready, pwm, period_start} !== 3'b111) begin
      n_bad++; $display("FAIL b2b_boundary ready/pwm/ps got %b%b%b want 111", cmd_ready, pwm, period_start);
    end
    @(negedge clk); cmd_valid = 1'b0;
    n_vec++; if ({cmd_ready, period_start} !== 2'b00) begin
      n_bad++; $display("FAIL b2b_second ready/ps got %b%b want 00", cmd_ready, period_start);
    end
    collect(14, pp, ps, bk, dr);
    n_vec++; if (pp[13:0] !== 14'h001F) begin n_bad++; $display("FAIL b2b_d6_pwm got %h want 001f", pp[13:0]); end
    collect(15, pp, ps, bk, dr);
    n_vec++; if (pp[14:0] !== 15'h03FF) begin n_bad++; $display("FAIL b2b_d10_pwm got %h want 03ff", pp[14:0]); end
    n_vec++; if (ps[14:0] !== 15'h0001) begin n_bad++; $display("FAIL b2b_d10_ps got %h want 0001", ps[14:0]); end
    n_vec++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_in_dead();
    send_cmd(4'd7, 1'b0);
    collect(1, pp, ps, bk, dr);
    n_vec++; if (bk[0] !== 1'b1) begin n_bad++; $display("FAIL rd_enter_brake got %b want 1", bk[0]); end
    collect(1, pp, ps, bk, dr);
    @(negedge clk); clk_div = 1'b1; rst_n = 1'b0;
    @(negedge clk); clk_div = 1'b0; rst_n = 1'b1;
    n_vec++; if ({brake, dir, pwm, cmd_ready, period_start} !== 5'b00010) begin
      n_bad++; $display("FAIL rd_reset brake/dir/pwm/ready/ps got %b%b%b%b%b want 00010",
                        brake, dir, pwm, cmd_ready, period_start);
    end
    collect(14, pp, ps, bk, dr);
    n_vec++; if (dr[13:0] !== 14'h0) begin n_bad++; $display("FAIL rd_dir got %h want 0", dr[13:0]); end
    n_vec++; if (bk[13:0] !== 14'h0) begin n_bad++; $display("FAIL rd_brake got %h want 0", bk[13:0]); end
    n_vec++; if (pp[13:0] !== 14'h0) begin n_bad++; $display("FAIL rd_pwm got %h want 0", pp[13:0]); end
  endtask

  task automatic test_clk_div_hold();
    logic [3:0] exp_pwm;
    logic [3:0] exp_ps1;
    int         ps_cnt;
    exp_pwm = 4'b0111;
    exp_ps1 = 4'b0001;
    send_cmd(4'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      ps_cnt = 0;
      @(negedge clk); clk_div = 1'b1;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (period_start === 1'b1) ps_cnt++;
      end
      clk_div = 1'b0;
      repeat (5) @(negedge clk);
      n_vec++; if (pwm !== exp_pwm[k]) begin n_bad++; $display("FAIL hold_pwm[%0d] got %b want %b", k, pwm, exp_pwm[k]); end
      n_vec++; if (ps_cnt !== int'(exp_ps1[k])) begin
        n_bad++; $display("FAIL hold_ps[%0d] got %0d want %0d", k, ps_cnt, exp_ps1[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_duty5();
    test_duty_0_15();
    test_reverse();
    test_back_to_back();
    test_reset_in_dead();
    test_clk_div_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/motor_pwm.md
MOTOR_PWM -- requirements
Module: motor_pwm

Interface
REQ-001 Parameter PWM_BITS, default 8: duty and counter width; PWM period is 2^PWM_BITS-1 ticks.
REQ-002 Parameter DEAD_TICKS, default 4, range 1..255: brake interval, in ticks, on a direction reversal.
REQ-003 clk100MHz  input  1  system clock, 100 MHz; one clock, all logic on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 clk_div  input  1  slow clock from the frequency divider; sampled in clk100MHz domain, not used as a clock.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_duty  input  PWM_BITS  requested duty, in ticks high per period.
REQ-009 cmd_dir  input  1  requested direction: 0 forward, 1 reverse.
REQ-010 pwm  output  1  motor enable PWM, registered.
REQ-011 dir  output  1  motor direction, registered.
REQ-012 brake  output  1  high during dead time, registered.
REQ-013 period_start  output  1  one-cycle pulse when a PWM period begins.

Function
REQ-014 tick SHALL be high for exactly one clk100MHz cycle: the first cycle in which clk_div=1 after clk_div=0 (clk_div_q = clk_div delayed one cycle).
REQ-015 All state (cnt, pwm, dir, brake, period_start, FSM) SHALL change only on edges where tick=1, except command acceptance and period_start deassertion.
REQ-016 cnt SHALL count 0..2^PWM_BITS-2 in RUN, advancing by 1 per tick and wrapping to 0 (boundary).
REQ-017 In RUN, pwm SHALL be registered as (cnt_next < duty_act); duty_act=0 gives constant 0, duty_act=2^PWM_BITS-1 gives constant 1.
REQ-018 A command SHALL be accepted when cmd_valid=1 and cmd_ready=1; it is stored in a one-entry pending register; cmd_ready=0 while pending is full.
REQ-019 Pending SHALL be applied only at a RUN boundary tick; a command accepted in the same cycle as a boundary tick waits for the next boundary.
REQ-020 Pending with cmd_dir equal to dir: duty_act takes cmd_duty at the boundary, takes effect in the new period; pending cleared.
REQ-021 Pending with a different direction: at the boundary, FSM enters DEAD; pending is moved to a target register and cleared; pwm=0 and brake=1 from that edge.
REQ-022 DEAD SHALL last DEAD_TICKS ticks; on the final tick, FSM returns to RUN, dir and duty_act take the target, brake=0, cnt=0, and pwm is evaluated for cnt=0.
REQ-023 A command accepted during DEAD SHALL stay pending until the first boundary after DEAD exit.
REQ-024 period_start SHALL pulse for one cycle on each edge where cnt becomes 0 in RUN, including DEAD exit; it is never asserted in DEAD.
REQ-025 FSM states: RUN and DEAD only. Transitions: RUN to DEAD per REQ-021, DEAD to RUN per REQ-022.

Reset
REQ-026 When rst_n=0 at a clock edge: FSM=RUN, cnt=0, duty_act=0, dir=0, pwm=0, brake=0, period_start=0, pending cleared, cmd_ready=1, clk_div_q=0.
REQ-027 Reset SHALL take priority over tick and command acceptance, including mid-DEAD; the target is discarded.

Structure
REQ-028 Shared package motor_pkg: FSM state encoding, PWM_BITS default, DEAD_TICKS default.
REQ-029 Sub-module rise_detect: clk_div_q register plus tick generation.

Verification (clk_div at 1 kHz; PWM_BITS=4 so period is 15 ticks; DEAD_TICKS=4)
REQ-030 Reset, then cmd duty=5, dir=0 -> after the next boundary, pwm is high 5 ticks and low 10 ticks per period; period_start every 15 ticks.
REQ-031 duty=0, then duty=15 -> pwm constant 0 for a whole period, then constant 1; no glitch at the boundary.
REQ-032 Running at duty=8, dir=0, then cmd duty=3, dir=1 -> at the boundary pwm=0 and brake=1 for 4 ticks; then dir=1, brake=0, pwm high 3 of 15 ticks.
REQ-033 Two back-to-back cmd_valid cycles -> first accepted, cmd_ready=0 until the boundary, second accepted the cycle after it clears; applied at the following boundary.
REQ-034 rst_n=0 during tick 2 of DEAD -> next cycle: brake=0, dir=0, pwm=0, cmd_ready=1; target is never applied.
REQ-035 clk_div held high for many cycles -> exactly one tick per rising edge.
